// File: rtl/decoder_layer_sched_pkg.sv
// -----------------------------------------------------------------------------
// decoder_layer_sched_pkg
//   Shared definitions for the layered LDPC decoder scheduler: default
//   geometry constants and the scheduler FSM state encoding.
//   No ports; imported by decoder_layer_sched.
// -----------------------------------------------------------------------------
package decoder_layer_sched_pkg;

  // Default decoder geometry
  localparam int DEF_LAYERS    = 2;   // layers per iteration (1 or 2)
  localparam int DEF_ADDRWIDTH = 5;   // row-block address width
  localparam int DEF_ADDRDEPTH = 20;  // row-block addresses per layer
  localparam int DEF_MAXITER   = 8;   // decoding iterations per frame
  localparam int DEF_ITERBITS  = 4;   // iteration counter width

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a frame start
    READ = 2'd1,  // streaming one layer of reads to the row unit
    WAIT = 2'd2,  // draining write-backs before the next layer
    FIN  = 2'd3   // one-cycle end-of-frame
  } state_t;

endpackage : decoder_layer_sched_pkg

// File: rtl/decoder_layer_sched.sv
// -----------------------------------------------------------------------------
// decoder_layer_sched
//   Layer/iteration scheduler for a layered LDPC decoder. For each frame it
//   issues ADDRDEPTH reads per layer, LAYERS layers per iteration, MAXITER
//   iterations. Between layers it stalls until every write-back of the
//   current layer has returned, so the next layer never reads stale LLRs.
//
// Ports
//   clk             : clock
//   rst             : synchronous active-low reset
//   start           : frame start request (sampled in IDLE only)
//   wren            : LLR write-back strobe from the row unit
//   rden_LLR_regin  : LLR-memory read enable
//   rdlayer_regin   : layer index of the current read
//   rdaddress_regin : read address
//   rden_E          : E-memory read enable (read enable delayed one cycle,
//                     suppressed during iteration 0)
//   busy            : frame in progress
//   done            : one-cycle end-of-frame pulse
//   iter            : current iteration index (holds after the frame)
// -----------------------------------------------------------------------------
module decoder_layer_sched
  import decoder_layer_sched_pkg::*;
#(
  parameter int LAYERS    = DEF_LAYERS,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int ADDRDEPTH = DEF_ADDRDEPTH,
  parameter int MAXITER   = DEF_MAXITER,
  parameter int ITERBITS  = DEF_ITERBITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 wren,
  output logic                 rden_LLR_regin,
  output logic                 rdlayer_regin,
  output logic [ADDRWIDTH-1:0] rdaddress_regin,
  output logic                 rden_E,
  output logic                 busy,
  output logic                 done,
  output logic [ITERBITS-1:0]  iter
);

  localparam logic [ADDRWIDTH-1:0] LAST_ADDR  = ADDRWIDTH'(ADDRDEPTH - 1);
  localparam logic [ADDRWIDTH:0]   WR_TARGET  = (ADDRWIDTH + 1)'(ADDRDEPTH);
  localparam logic                 LAST_LAYER = 1'(LAYERS - 1);
  localparam logic [ITERBITS-1:0]  LAST_ITER  = ITERBITS'(MAXITER - 1);

  state_t                state_q, state_d;
  logic [ADDRWIDTH-1:0]  addr_q, addr_d;
  logic                  layer_q, layer_d;
  logic [ITERBITS-1:0]   iter_q, iter_d;
  logic [ADDRWIDTH:0]    wcnt_q, wcnt_d;
  logic [ADDRWIDTH:0]    wcnt_inc;

  logic                  rden_q, rden_d;
  logic                  rdlayer_q, rdlayer_d;
  logic [ADDRWIDTH-1:0]  rdaddr_q, rdaddr_d;
  logic                  rden_e_q, rden_e_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    layer_d = layer_q;
    iter_d  = iter_q;
    wcnt_d  = wcnt_q;

    // Write-back count including this cycle's strobe; the WAIT exit test uses
    // it so a strobe on the exit edge is counted before the clear.
    wcnt_inc = wcnt_q + (ADDRWIDTH + 1)'(wren);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          addr_d  = '0;
          layer_d = 1'b0;
          iter_d  = '0;
          wcnt_d  = '0;
        end
      end

      READ: begin
        wcnt_d = wcnt_inc;
        if (addr_q == LAST_ADDR) begin
          state_d = WAIT;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      WAIT: begin
        wcnt_d = wcnt_inc;
        if (wcnt_inc == WR_TARGET) begin
          wcnt_d = '0;
          if (layer_q == LAST_LAYER) begin
            if (iter_q == LAST_ITER) begin
              state_d = FIN;
            end else begin
              layer_d = 1'b0;
              iter_d  = iter_q + 1'b1;
              state_d = READ;
            end
          end else begin
            layer_d = layer_q + 1'b1;
            state_d = READ;
          end
        end
      end

      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next-state values so that, in any
    // cycle, the registered read strobe/address/layer match state_q/addr_q.
    rden_d    = (state_d == READ);
    rdaddr_d  = addr_d;
    rdlayer_d = layer_d;
    busy_d    = (state_d == READ) || (state_d == WAIT);
    done_d    = (state_d == FIN);

    // E memory is read one cycle behind the LLR read to line up with the row
    // unit's input register; it holds nothing useful in iteration 0.
    rden_e_d  = rden_q && (iter_q != '0);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      // NOTE: all flops here are control/output state and must come up
      // known, so each is reset; there is no storage array to exempt.
      state_q   <= IDLE;
      addr_q    <= '0;
      layer_q   <= 1'b0;
      iter_q    <= '0;
      wcnt_q    <= '0;
      rden_q    <= 1'b0;
      rdlayer_q <= 1'b0;
      rdaddr_q  <= '0;
      rden_e_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      layer_q   <= layer_d;
      iter_q    <= iter_d;
      wcnt_q    <= wcnt_d;
      rden_q    <= rden_d;
      rdlayer_q <= rdlayer_d;
      rdaddr_q  <= rdaddr_d;
      rden_e_q  <= rden_e_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rden_LLR_regin  = rden_q;
  assign rdlayer_regin   = rdlayer_q;
  assign rdaddress_regin = rdaddr_q;
  assign rden_E          = rden_e_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign iter            = iter_q;

endmodule : decoder_layer_sched

// File: tb/tb_decoder_layer_sched.sv
// -----------------------------------------------------------------------------
// tb_decoder_layer_sched
//   Directed bench for decoder_layer_sched at default parameters. The row unit
//   is modelled as wren = rden_LLR_regin delayed 13 cycles. Cycle numbering:
//   start is driven in cycle 0 and sampled at the edge that begins cycle 1;
//   outputs are sampled 1 time unit after each rising edge.
//   Expected timeline: layer segment g (0..15) reads in cycles 1+33g..20+33g,
//   waits 13 cycles, and done pulses in cycle 529.
// -----------------------------------------------------------------------------
module tb_decoder_layer_sched;

  localparam int AD      = 20;
  localparam int LAT     = 13;
  localparam int PERIOD  = AD + LAT;          // 33 cycles per layer segment
  localparam int NLAYER  = 2;
  localparam int NITER   = 8;
  localparam int NSEG    = NLAYER * NITER;    // 16 layer segments per frame
  localparam int FIN_CYC = 1 + PERIOD * NSEG; // 529

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       wren_extra = 1'b0;
  logic       wren;
  logic       rden_LLR_regin;
  logic       rdlayer_regin;
  logic [4:0] rdaddress_regin;
  logic       rden_E;
  logic       busy;
  logic       done;
  logic [3:0] iter;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Row-unit stub: write-back 13 cycles after each read
  logic [LAT-1:0] wr_pipe = '0;
  always @(posedge clk) begin
    if (!rst) wr_pipe <= '0;
    else      wr_pipe <= {wr_pipe[LAT-2:0], rden_LLR_regin};
  end
  assign wren = wr_pipe[LAT-1] | wren_extra;

  decoder_layer_sched dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .wren            (wren),
    .rden_LLR_regin  (rden_LLR_regin),
    .rdlayer_regin   (rdlayer_regin),
    .rdaddress_regin (rdaddress_regin),
    .rden_E          (rden_E),
    .busy            (busy),
    .done            (done),
    .iter            (iter)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle c (relative to start in cycle 0) carries a read
  function automatic bit exp_read(input int c);
    if (c < 1) return 1'b0;
    return ((c - 1) / PERIOD < NSEG) && ((c - 1) % PERIOD < AD);
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0; start = 1'b1; wren_extra = 1'b1;
    tick(); tick();
    checks++;
    if ({rden_LLR_regin, rdlayer_regin, rdaddress_regin, rden_E, busy, done, iter} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got rden=%b layer=%b addr=%0d rdenE=%b busy=%b done=%b iter=%0d exp all 0",
               rden_LLR_regin, rdlayer_regin, rdaddress_regin, rden_E, busy, done, iter);
    end
    start = 1'b0; wren_extra = 1'b0; rst = 1'b1;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || rden_LLR_regin !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b rden=%b exp 0 0", busy, rden_LLR_regin);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_first_layer_and_gap();
    int c;
    start = 1'b1; tick(); start = 1'b0;  // cycle 1
    for (int k = 1; k <= AD; k++) begin
      checks++;
      if (rden_LLR_regin !== 1'b1 || rdaddress_regin !== 5'(k - 1) || rdlayer_regin !== 1'b0 ||
          rden_E !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL first_layer c=%0d got rden=%b addr=%0d layer=%b rdenE=%b busy=%b exp 1 %0d 0 0 1",
                 k, rden_LLR_regin, rdaddress_regin, rdlayer_regin, rden_E, busy, k - 1);
      end
      tick();
    end
    for (int k = AD + 1; k <= PERIOD; k++) begin
      checks++;
      if (rden_LLR_regin !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL layer_gap c=%0d got rden=%b busy=%b exp 0 1", k, rden_LLR_regin, busy);
      end
      tick();
    end
    // cycle 34: first layer-1 read
    checks++;
    if (rden_LLR_regin !== 1'b1 || rdlayer_regin !== 1'b1 || rdaddress_regin !== 5'd0) begin
      errors++;
      $display("FAIL layer1_start got rden=%b layer=%b addr=%0d exp 1 1 0",
               rden_LLR_regin, rdlayer_regin, rdaddress_regin);
    end
    c = PERIOD + 1;
    while (done !== 1'b1 && c < FIN_CYC + 50) begin
      tick();
      c++;
    end
    checks++;
    if (c !== FIN_CYC || busy !== 1'b0 || iter !== 4'd7) begin
      errors++;
      $display("FAIL done_timing got cycle=%0d busy=%b iter=%0d exp %0d 0 7", c, busy, iter, FIN_CYC);
    end
    tick();
    checks++;
    if (done !== 1'b0 || iter !== 4'd7) begin
      errors++;
      $display("FAIL done_single_pulse got done=%b iter=%0d exp 0 7", done, iter);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Runs one frame from a start in cycle 0 and checks every cycle
  task automatic run_frame(input string tag);
    int reads = 0;
    int dones = 0;
    int ehits = 0;
    int g, off, exp_iter, exp_prev;
    bit er, ee, eb, ed;
    logic [4:0] prev_addr = '0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= FIN_CYC + 2; c++) begin
      g        = (c - 1) / PERIOD;
      off      = (c - 1) % PERIOD;
      er       = exp_read(c);
      ee       = exp_read(c - 1) && ((c - 2) / PERIOD >= NLAYER);
      eb       = (c < FIN_CYC);
      ed       = (c == FIN_CYC);
      exp_iter = (g < NSEG) ? g / NLAYER : NITER - 1;
      exp_prev = (c - 2) % PERIOD;

      checks++;
      if (rden_LLR_regin !== er) begin
        errors++;
        $display("FAIL %s rden c=%0d got %b exp %b", tag, c, rden_LLR_regin, er);
      end
      if (er) begin
        checks++;
        if (rdaddress_regin !== 5'(off) || rdlayer_regin !== 1'(g % 2)) begin
          errors++;
          $display("FAIL %s read_addr c=%0d got addr=%0d layer=%b exp %0d %0d",
                   tag, c, rdaddress_regin, rdlayer_regin, off, g % 2);
        end
      end
      checks++;
      if (rden_E !== ee) begin
        errors++;
        $display("FAIL %s rden_E c=%0d got %b exp %b", tag, c, rden_E, ee);
      end
      if (ee) begin
        checks++;
        if (prev_addr !== 5'(exp_prev)) begin
          errors++;
          $display("FAIL %s rden_E_addr c=%0d got %0d exp %0d", tag, c, prev_addr, exp_prev);
        end
      end
      checks++;
      if (busy !== eb || done !== ed || iter !== 4'(exp_iter)) begin
        errors++;
        $display("FAIL %s status c=%0d got busy=%b done=%b iter=%0d exp %b %b %0d",
                 tag, c, busy, done, iter, eb, ed, exp_iter);
      end
      if (rden_LLR_regin === 1'b1) reads++;
      if (done === 1'b1) dones++;
      if (rden_E === 1'b1) ehits++;
      prev_addr = rdaddress_regin;
      tick();
    end
    checks++;
    if (reads !== AD * NSEG) begin
      errors++;
      $display("FAIL %s read_count got %0d exp %0d", tag, reads, AD * NSEG);
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL %s done_count got %0d exp 1", tag, dones);
    end
    checks++;
    if (ehits !== AD * NLAYER * (NITER - 1)) begin
      errors++;
      $display("FAIL %s rden_E_count got %0d exp %0d", tag, ehits, AD * NLAYER * (NITER - 1));
    end
  endtask

  task automatic test_full_frame();
    run_frame("full_frame");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mid_reset();
    checks++;
    if (iter !== 4'd7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL iter_hold got iter=%0d busy=%b exp 7 0", iter, busy);
    end
    start = 1'b1; tick(); start = 1'b0;  // cycle 1
    checks++;
    if (iter !== 4'd0 || busy !== 1'b1 || rdaddress_regin !== 5'd0) begin
      errors++;
      $display("FAIL restart got iter=%0d busy=%b addr=%0d exp 0 1 0", iter, busy, rdaddress_regin);
    end
    tick(); tick(); tick();              // cycle 4
    start = 1'b1; tick(); start = 1'b0;  // cycle 5, start seen while busy
    checks++;
    if (rden_LLR_regin !== 1'b1 || rdaddress_regin !== 5'd4) begin
      errors++;
      $display("FAIL start_ignored_busy got rden=%b addr=%0d exp 1 4", rden_LLR_regin, rdaddress_regin);
    end
    tick(); tick(); tick();              // cycle 8
    checks++;
    if (rdaddress_regin !== 5'd7) begin
      errors++;
      $display("FAIL pre_reset_addr got %0d exp 7", rdaddress_regin);
    end
    rst = 1'b0; tick();                  // reset sampled
    checks++;
    if ({rden_LLR_regin, rdlayer_regin, rdaddress_regin, rden_E, busy, done, iter} !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got rden=%b layer=%b addr=%0d rdenE=%b busy=%b done=%b iter=%0d exp all 0",
               rden_LLR_regin, rdlayer_regin, rdaddress_regin, rden_E, busy, done, iter);
    end
    rst = 1'b1;
    wren_extra = 1'b1; tick(); tick(); wren_extra = 1'b0;
    tick(); tick();
    checks++;
    if (rden_LLR_regin !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_mid_reset got rden=%b busy=%b done=%b exp 0 0 0",
               rden_LLR_regin, busy, done);
    end
    wren_extra = 1'b1; tick(); wren_extra = 1'b0;
  endtask

  task automatic test_after_reset();
    run_frame("after_reset");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_first_layer_and_gap();
    test_full_frame();
    test_mid_reset();
    test_after_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decoder_layer_sched
